sub_shift_rows_seq: RTL and testbench
=====================================

Name: sub_shift_rows_seq

Overview:
- Iterative SubBytes + ShiftRows stage for the AES encryption datapath. It sits directly upstream of MixColumns and drives its 128-bit state input.
- It accepts one 128-bit state per valid/ready handshake. It substitutes COLS_PER_CYCLE output columns per clock through shared S-box lanes.
- The result is held on a valid/ready output until MixColumns' consumer register takes it.
- It trades area (4·COLS_PER_CYCLE S-boxes instead of 16) for latency.

Parameters:
- COLS_PER_CYCLE, 1, output columns produced per busy cycle. Legal values are 1, 2, 4. Busy cycles NB = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  128  AES state, column-major; byte n=4c+r at bits [127-8n -: 8]
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  ShiftRows(SubBytes(in_state)), same byte layout
- busy  output  1  substitution in progress (state BUSY)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, col counter=0, captured state register=0, out_state=0.
  - in_ready=1 once rst is released (combinational from IDLE); out_valid=0, busy=0.
  - Reset mid-BUSY or mid-DONE discards the transaction. No partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, capture in_state into the internal register, set col=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge writes output columns col..col+COLS_PER_CYCLE-1, then col += COLS_PER_CYCLE. After the edge that writes column 3, go to DONE.
  - DONE: out_valid=1, in_ready=0. out_state is stable while out_valid=1 and out_ready=0, for any number of cycles. On an edge with out_ready=1, go to IDLE; out_valid drops after that edge and out_state keeps its last value.
- Per-byte function: out byte (col j, row r) = SBOX(in byte (col (j+r) mod 4, row r)). SBOX is the FIPS-197 forward S-box.
- Timing:
  - Latency from accepting edge to out_valid=1 is NB cycles: 4, 2 or 1.
  - Minimum period between accepts is NB+2 cycles, because a new input is not accepted in the same cycle as the output handshake.
- in_state is don't-care outside the accepting edge. in_valid while not in IDLE is ignored and must be held by the source.
- out_ready while not in DONE is ignored.
- col counter is 2 bits. It wraps to 0 on the transition to DONE, so no stale column is rewritten.
- Output columns not yet written during BUSY hold their previous values. These are invisible because out_valid=0.

Test Plan:
- FIPS-197 round-1 vector, COLS_PER_CYCLE=1:
  - Stimulus: in_state=193DE3BEA0F4E22B9AC68D2AE9F84808, out_ready=1.
  - Required: out_valid rises exactly 4 cycles after accept, with out_state=D4BF5D30E0B452AEB84111F11E2798E5; in_ready=0 throughout BUSY/DONE.
- All-zero input -> out_state=63636363636363636363636363636363.
- in_state=53 repeated in all 16 bytes -> out_state=ED in all 16 bytes.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new state.
  - Required: out_state unchanged, in_ready=0, new state not captured. After out_ready=1 for one edge: IDLE, then the new state is accepted.
- Async reset:
  - Stimulus: assert rst between clock edges during BUSY (after 2 columns).
  - Required: out_valid=0, busy=0, out_state=0 immediately. After release, in_ready=1 and a fresh vector completes correctly.
- Parameter sweep: repeat the FIPS vector with COLS_PER_CYCLE=2 and 4 -> same out_state, with latency 2 and 1 cycles respectively.

Source files
------------

// File: rtl/sub_shift_rows_seq.sv
// Iterative AES SubBytes + ShiftRows: COLS_PER_CYCLE output columns per busy cycle,
// sharing 4*COLS_PER_CYCLE S-box lanes; result held on a valid/ready output.
module sub_shift_rows_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Byte i of the FIPS-197 forward S-box sits at bits [8*(255-i) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[8*(255-int'(a)) +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q;
  logic [127:0]  cap_q;
  logic [127:0]  out_q;
  logic [127:0]  out_d;
  logic          last_col;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE, out_valid only in DONE; out_state is stable in DONE.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;

  assign last_col = (({1'b0, col_q} + 3'(COLS_PER_CYCLE)) == 3'd4);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_col)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output column dst, row r takes the byte from column (dst + r) mod 4, same row.
  always_comb begin
    logic [1:0] dst;
    logic [1:0] src;
    out_d = out_q;
    dst   = '0;
    src   = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int r = 0; r < 4; r++) begin
        dst = col_q + 2'(k);
        src = dst + 2'(r);
        out_d[8*(15 - (4*int'(dst) + r)) +: 8] = sbox(cap_q[8*(15 - (4*int'(src) + r)) +: 8]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      cap_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        cap_q <= in_state;
        col_q <= '0;
      end
      // col wraps to 0 on the final busy edge, so DONE never rewrites a column.
      if (state_q == BUSY) begin
        out_q <= out_d;
        col_q <= col_q + STEP;
      end
    end
  end

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// Bench for sub_shift_rows_seq: three instances (COLS_PER_CYCLE = 1, 2, 4) share stimulus
// and are checked against a model whose S-box is derived from GF(2^8) inversion.
module tb_sub_shift_rows_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_state [3];

  int total = 0;
  int bad = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_q [$];
  logic [127:0] last_exp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_shift_rows_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = '0;
      logic [7:0] s, t;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv;
      t = inv;
      for (int i = 0; i < 4; i++) begin
        t = rotl1(t);
        s = s ^ t;
      end
      sb[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int j = 0; j < 4; j++)
      for (int r = 0; r < 4; r++)
        o[8*(15 - (4*j + r)) +: 8] = sb[s[8*(15 - (4*((j + r) % 4) + r)) +: 8]];
    return o;
  endfunction

  // Called at a negedge with all instances idle; returns at the negedge after the accept.
  task automatic start_txn(input logic [127:0] s, input logic rdy);
    check("idle_ready", {125'b0, in_ready}, 128'd7);
    in_valid  = 1'b1;
    in_state  = s;
    out_ready = rdy;
    exp_q.push_back(model(s));
    @(negedge clk);
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // c = edges since accept; instance g needs nb = 4 >> g busy edges.
  task automatic check_run(input logic drain);
    logic [127:0] e;
    logic [2:0]   ev, er, eb;
    int cmax;
    e = exp_q.pop_front();
    last_exp = e;
    cmax = drain ? 5 : 4;
    for (int c = 0; c <= cmax; c++) begin
      for (int g = 0; g < 3; g++) begin
        int nb = 4 >> g;
        ev[g] = drain ? (c == nb) : (c >= nb);
        er[g] = drain ? (c > nb) : 1'b0;
        eb[g] = (c < nb);
        if (c >= nb) check($sformatf("out_state_g%0d_c%0d", g, c), out_state[g], e);
      end
      check($sformatf("out_valid_c%0d", c), {125'b0, out_valid}, {125'b0, ev});
      check($sformatf("in_ready_c%0d", c), {125'b0, in_ready}, {125'b0, er});
      check($sformatf("busy_c%0d", c), {125'b0, busy}, {125'b0, eb});
      if (c < cmax) @(negedge clk);
    end
  endtask

  task automatic run_txn(input logic [127:0] s);
    start_txn(s, 1'b1);
    check_run(1'b1);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  initial begin
    logic [127:0] s2;
    build_sbox();
    check("model_fips", model(FIPS_IN), FIPS_OUT);

    repeat (2) @(negedge clk);
    check("rst_out_state", out_state[0], '0);
    check("rst_out_valid", {125'b0, out_valid}, '0);
    check("rst_busy", {125'b0, busy}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(FIPS_IN);
    check("fips_direct", out_state[2], FIPS_OUT);
    run_txn('0);
    check("zero_direct", out_state[0], {16{8'h63}});
    run_txn({16{8'h53}});
    check("x53_direct", out_state[1], {16{8'hed}});

    // Backpressure: sit in DONE for 10 cycles while a new state is offered.
    start_txn(FIPS_IN, 1'b0);
    check_run(1'b0);
    s2 = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_state = s2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {125'b0, out_valid}, 128'd7);
      check("bp_ready", {125'b0, in_ready}, '0);
      for (int g = 0; g < 3; g++) check("bp_state", out_state[g], last_exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {125'b0, in_ready}, 128'd7);
    check("bp_release_valid", {125'b0, out_valid}, '0);
    check("bp_release_state", out_state[0], last_exp);
    exp_q.push_back(model(s2));
    @(negedge clk);
    in_valid = 1'b0;
    check_run(1'b1);

    // Asynchronous reset between edges, two columns into the slowest instance.
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {125'b0, out_valid}, '0);
    check("arst_busy", {125'b0, busy}, '0);
    for (int g = 0; g < 3; g++) check("arst_state", out_state[g], '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_ready", {125'b0, in_ready}, 128'd7);
    run_txn(FIPS_IN);

    for (int i = 0; i < 20; i++) begin
      run_txn({$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
